// File: rtl/usb_rx_pkg.sv
// Shared types and constants for the USB receive control unit.
package usb_rx_pkg;

  localparam int unsigned CNT_W = 7;

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    PID,
    DATA,
    EOP_WAIT,
    DONE,
    ERR,
    ERR_EOP
  } state_t;

  // Decoded packet codes presented on rx_packet
  localparam logic [2:0] RX_NONE  = 3'd0;
  localparam logic [2:0] RX_OUT   = 3'd1;
  localparam logic [2:0] RX_IN    = 3'd2;
  localparam logic [2:0] RX_DATA0 = 3'd3;
  localparam logic [2:0] RX_DATA1 = 3'd4;
  localparam logic [2:0] RX_ACK   = 3'd5;
  localparam logic [2:0] RX_NAK   = 3'd6;
  localparam logic [2:0] RX_UNSUP = 3'd7;

  // PID low nibbles as they arrive in rcv_byte
  localparam logic [3:0] PID_OUT   = 4'b0001;
  localparam logic [3:0] PID_IN    = 4'b1001;
  localparam logic [3:0] PID_DATA0 = 4'b0011;
  localparam logic [3:0] PID_DATA1 = 4'b1011;
  localparam logic [3:0] PID_ACK   = 4'b0010;
  localparam logic [3:0] PID_NAK   = 4'b1010;

endpackage

// File: rtl/usb_rx_rcu_pid_decode.sv
// PID byte check (high nibble must complement low nibble) and code mapping.
module usb_pid_decode
  import usb_rx_pkg::*;
(
  input  logic [7:0] pid_byte,
  output logic       valid_c,
  output logic [2:0] code_c
);

  always_comb begin
    valid_c = (pid_byte[7:4] == ~pid_byte[3:0]);
    case (pid_byte[3:0])
      PID_OUT:   code_c = RX_OUT;
      PID_IN:    code_c = RX_IN;
      PID_DATA0: code_c = RX_DATA0;
      PID_DATA1: code_c = RX_DATA1;
      PID_ACK:   code_c = RX_ACK;
      PID_NAK:   code_c = RX_NAK;
      default:   code_c = RX_UNSUP;
    endcase
  end

endmodule

// File: rtl/usb_rx_rcu.sv
// USB receive control unit: tracks packet framing, decodes the PID and
// steers DATA payload bytes into the receive FIFO.
module usb_rx_rcu
  import usb_rx_pkg::*;
#(
  parameter int unsigned MAX_BYTES = 66,
  parameter logic [7:0]  SYNC_BYTE = 8'h80
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       d_edge,
  input  logic       eop,
  input  logic       byte_received,
  input  logic [7:0] rcv_byte,
  input  logic       fifo_full,
  output logic       rcving,
  output logic       clear,
  output logic       flush,
  output logic       w_enable,
  output logic [2:0] rx_packet,
  output logic       rx_done,
  output logic       r_error
);

  state_t           state, next_state;
  logic [CNT_W-1:0] byte_count, next_count;
  logic [2:0]       next_packet;
  logic             next_error, next_clear, next_flush, next_wen, next_done;
  logic             pid_valid_c;
  logic [2:0]       pid_code_c;

  usb_pid_decode u_pid (
    .pid_byte (rcv_byte),
    .valid_c  (pid_valid_c),
    .code_c   (pid_code_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      byte_count <= '0;
      rx_packet  <= RX_NONE;
      r_error    <= 1'b0;
      rcving     <= 1'b0;
      clear      <= 1'b0;
      flush      <= 1'b0;
      w_enable   <= 1'b0;
      rx_done    <= 1'b0;
    end else begin
      state      <= next_state;
      byte_count <= next_count;
      rx_packet  <= next_packet;
      r_error    <= next_error;
      rcving     <= (next_state != IDLE);
      clear      <= next_clear;
      flush      <= next_flush;
      w_enable   <= next_wen;
      rx_done    <= next_done;
    end
  end

  // eop is always tested before byte_received so a coincident byte is dropped
  always_comb begin
    next_state  = state;
    next_count  = byte_count;
    next_packet = rx_packet;
    next_error  = r_error;
    next_clear  = 1'b0;
    next_flush  = 1'b0;
    next_wen    = 1'b0;
    next_done   = 1'b0;

    case (state)
      IDLE: begin
        if (d_edge) begin
          next_state  = SYNC;
          next_clear  = 1'b1;
          next_packet = RX_NONE;
          next_error  = 1'b0;
        end
      end
      SYNC: begin
        if (eop) begin
          next_state = ERR;
        end else if (byte_received) begin
          if (rcv_byte == SYNC_BYTE) begin
            next_state = PID;
            next_flush = 1'b1;
          end else begin
            next_state = ERR;
          end
        end
      end
      PID: begin
        if (eop) begin
          next_state = ERR;
        end else if (byte_received) begin
          if (!pid_valid_c) begin
            next_state = ERR;
          end else begin
            next_packet = pid_code_c;
            case (pid_code_c)
              RX_DATA0, RX_DATA1: begin
                next_state = DATA;
                next_count = '0;
              end
              RX_OUT, RX_IN, RX_ACK, RX_NAK: next_state = EOP_WAIT;
              default:                       next_state = ERR;
            endcase
          end
        end
      end
      DATA: begin
        if (eop) begin
          next_state = (byte_count >= CNT_W'(2)) ? DONE : ERR;
        end else if (byte_received) begin
          if (fifo_full || (byte_count >= CNT_W'(MAX_BYTES))) begin
            next_state = ERR;
          end else begin
            next_wen   = 1'b1;
            next_count = byte_count + CNT_W'(1);
          end
        end
      end
      EOP_WAIT: begin
        if (eop) begin
          next_state = DONE;
        end else if (byte_received) begin
          next_state = ERR;
        end
      end
      DONE:    if (!eop) next_state = IDLE;
      ERR:     if (eop) next_state = ERR_EOP;
      ERR_EOP: if (!eop) next_state = IDLE;
      default: next_state = IDLE;
    endcase

    // Entry-only effects
    if ((next_state == ERR) && (state != ERR)) next_error = 1'b1;
    if ((next_state == DONE) && (state != DONE)) next_done = 1'b1;
  end

endmodule

// File: doc/usb_rx_rcu.md
USB_RX_RCU -- requirements
Module: usb_rx_rcu

Interface
REQ-001 Parameter MAX_BYTES, default 66, maximum DATA-packet bytes stored (64 payload + 2 CRC16).
REQ-002 Parameter SYNC_BYTE, default 8'h80, expected sync pattern as presented on rcv_byte.
REQ-003 clk  input  1  system clock; all state changes on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 d_edge  input  1  one-cycle pulse on the first line transition (start of packet).
REQ-006 eop  input  1  level, high while an SE0 end-of-packet is on the bus.
REQ-007 byte_received  input  1  one-cycle pulse from the shift-register byte counter when 8 unstuffed bits are complete.
REQ-008 rcv_byte  input  8  completed byte, valid in the byte_received cycle.
REQ-009 fifo_full  input  1  receive FIFO cannot accept a write.
REQ-010 rcving  output  1  packet reception in progress.
REQ-011 clear  output  1  one-cycle pulse clearing the shift-register bit counters.
REQ-012 flush  output  1  one-cycle pulse emptying the receive FIFO.
REQ-013 w_enable  output  1  one-cycle FIFO write strobe for rcv_byte.
REQ-014 rx_packet  output  3  decoded PID: 0 none, 1 OUT, 2 IN, 3 DATA0, 4 DATA1, 5 ACK, 6 NAK, 7 unsupported.
REQ-015 rx_done  output  1  one-cycle pulse on good packet completion.
REQ-016 r_error  output  1  sticky receive-error flag.

Function
REQ-017 States: IDLE, SYNC, PID, DATA, EOP_WAIT, DONE, ERR, ERR_EOP; rcving SHALL be 1 in every state except IDLE.
REQ-018 IDLE: d_edge -> SYNC; same cycle pulse clear, set rx_packet=0, clear r_error.
REQ-019 SYNC: byte_received with rcv_byte==SYNC_BYTE -> PID with flush pulse; byte_received with mismatch -> ERR; eop -> ERR.
REQ-020 PID: valid PID requires rcv_byte[7:4]==~rcv_byte[3:0]; on byte_received, register rx_packet per low nibble (0001 OUT, 1001 IN, 0011 DATA0, 1011 DATA1, 0010 ACK, 1010 NAK, other valid 7).
REQ-021 PID transitions: DATA0/DATA1 -> DATA; codes 1,2,5,6 -> EOP_WAIT; invalid check or code 7 -> ERR; eop -> ERR.
REQ-022 DATA: byte_received with fifo_full=0 and byte_count<MAX_BYTES -> w_enable pulse same cycle, byte_count+1; with fifo_full=1 or byte_count==MAX_BYTES -> ERR, no write.
REQ-023 DATA: eop with byte_count>=2 -> DONE; eop with byte_count<2 -> ERR.
REQ-024 byte_count SHALL be 7 bits, zeroed on entry to DATA, never wrap.
REQ-025 EOP_WAIT: eop -> DONE; byte_received -> ERR.
REQ-026 DONE: rx_done pulses on entry cycle only; stays until eop=0, then IDLE.
REQ-027 ERR: r_error set on entry; eop -> ERR_EOP; ERR_EOP: eop=0 -> IDLE with r_error held.
REQ-028 Simultaneous eop and byte_received: eop wins, byte discarded, no w_enable.
REQ-029 d_edge outside IDLE SHALL be ignored.
REQ-030 All outputs registered-state decoded; w_enable/clear/flush/rx_done never high longer than one cycle.

Reset
REQ-031 rst=1 forces IDLE, byte_count=0, rx_packet=0, r_error=0, all strobes 0, immediately and independent of clk, including mid-packet.

Structure
REQ-032 Package usb_rx_pkg holds the state enum, rx_packet code constants, and PID nibble constants.
REQ-033 One sub-module natural: usb_pid_decode (combinational nibble check and code map); byte counter stays inline.

Verification
REQ-034 d_edge, bytes 80, C3, 11, 22, 33, 44, eop -> four w_enable pulses, rx_packet=3, rx_done one pulse, r_error=0.
REQ-035 d_edge, bytes 80, 69, eop -> rx_packet=2, no w_enable, rx_done pulse.
REQ-036 d_edge, byte 81 -> r_error=1 after next eop; next d_edge clears r_error.
REQ-037 d_edge, 80, 4B, fifo_full=1 at third byte -> no w_enable, ERR, r_error=1.
REQ-038 d_edge, 80, C3, 11, eop coincident with byte_received -> one w_enable only, r_error=1.
REQ-039 rst pulse during DATA after 3 writes -> all outputs 0 asynchronously, next packet decodes normally.
